// File: rtl/rlo_stack_unit_pkg.sv
// Shared definitions for the RLO stack unit: opcode map, default nesting depth
// and the layout of one saved nesting level.
package rlo_stack_unit_pkg;

  localparam int STACK_DEPTH_DEFAULT = 8;

  typedef enum logic [3:0] {
    OP_NOP      = 4'h0,
    OP_LD       = 4'h1,
    OP_LDN      = 4'h2,
    OP_AND      = 4'h3,
    OP_ANDN     = 4'h4,
    OP_OR       = 4'h5,
    OP_ORN      = 4'h6,
    OP_XOR      = 4'h7,
    OP_PUSH_AND = 4'h8,
    OP_PUSH_OR  = 4'h9,
    OP_POP      = 4'hA,
    OP_SET      = 4'hB,
    OP_CLR      = 4'hC,
    OP_NOT      = 4'hD,
    OP_JMPC     = 4'hE,
    OP_JMPCN    = 4'hF
  } opcode_t;

  // Operation that combines a saved RLO with the inner result on POP.
  typedef enum logic {
    PEND_AND = 1'b0,
    PEND_OR  = 1'b1
  } pend_op_t;

  typedef struct packed {
    pend_op_t op;
    logic     value;
  } stack_entry_t;

endpackage

// File: rtl/rlo_stack_unit_lifo.sv
// LIFO of saved nesting levels; push/pop are ignored when full/empty so the
// caller only has to flag the error.
module rlo_lifo
  import rlo_stack_unit_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH),
  localparam int DW   = AW + 1
) (
  input  logic         CLK,
  input  logic         CPU_Reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  stack_entry_t i_data,
  output stack_entry_t o_top,
  output logic [DW-1:0] o_depth,
  output logic         o_full,
  output logic         o_empty
);

  stack_entry_t     r_mem [DEPTH];
  logic [DW-1:0]    r_depth;
  logic [DW-1:0]    w_top_ptr;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;

  assign o_full    = (r_depth == DW'(DEPTH));
  assign o_empty   = (r_depth == '0);
  assign w_top_ptr = r_depth - DW'(1);
  assign w_wr_idx  = r_depth[AW-1:0];
  assign w_top_idx = w_top_ptr[AW-1:0];
  assign o_top     = r_mem[w_top_idx];
  assign o_depth   = r_depth;

  // NOTE: storage has no reset; entries at or above depth are never read, and
  // leaving them unreset lets the array map onto plain registers or RAM.
  always_ff @(posedge CLK) begin
    if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      r_depth <= '0;
    end else if (i_push && !o_full) begin
      r_depth <= r_depth + DW'(1);
    end else if (i_pop && !o_empty) begin
      r_depth <= r_depth - DW'(1);
    end
  end

endmodule

// File: rtl/rlo_stack_unit.sv
// PLC result-of-logic-operation unit: opcode decode, RLO register, sticky
// stack error flags and the conditional-jump decision pulse.
module rlo_stack_unit
  import rlo_stack_unit_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic                         CLK,
  input  logic                         CPU_Reset,
  input  logic                         RLO_EN,
  input  logic [3:0]                   RLO_OPCode,
  input  logic                         RLO_SrcSel,
  input  logic                         RLO_CmpResult,
  input  logic                         RLO_BitIn,
  output logic                         RLO_Value,
  output logic [$clog2(STACK_DEPTH):0] RLO_Depth,
  output logic                         RLO_Overflow,
  output logic                         RLO_Underflow,
  output logic                         RLO_CondTaken
);

  opcode_t      w_op;
  logic         w_opnd;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  stack_entry_t w_push_entry;
  stack_entry_t w_top;
  logic         w_rlo_nxt;
  logic         w_cond_nxt;
  logic         w_ovf_set;
  logic         w_unf_set;

  logic         r_rlo;
  logic         r_ovf;
  logic         r_unf;
  logic         r_cond;

  assign w_op   = opcode_t'(RLO_OPCode);
  assign w_opnd = RLO_SrcSel ? RLO_BitIn : RLO_CmpResult;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_rlo_nxt    = r_rlo;
    w_cond_nxt   = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_ovf_set    = 1'b0;
    w_unf_set    = 1'b0;
    w_push_entry = '{op: PEND_AND, value: r_rlo};
    if (RLO_EN) begin
      case (w_op)
        OP_LD:   w_rlo_nxt = w_opnd;
        OP_LDN:  w_rlo_nxt = !w_opnd;
        OP_AND:  w_rlo_nxt = r_rlo & w_opnd;
        OP_ANDN: w_rlo_nxt = r_rlo & !w_opnd;
        OP_OR:   w_rlo_nxt = r_rlo | w_opnd;
        OP_ORN:  w_rlo_nxt = r_rlo | !w_opnd;
        OP_XOR:  w_rlo_nxt = r_rlo ^ w_opnd;
        OP_PUSH_AND, OP_PUSH_OR: begin
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_push          = 1'b1;
            w_push_entry.op = (w_op == OP_PUSH_OR) ? PEND_OR : PEND_AND;
            w_rlo_nxt       = w_opnd;
          end
        end
        OP_POP: begin
          if (w_empty) begin
            w_unf_set = 1'b1;
          end else begin
            w_pop     = 1'b1;
            w_rlo_nxt = (w_top.op == PEND_OR) ? (w_top.value | r_rlo)
                                              : (w_top.value & r_rlo);
          end
        end
        OP_SET:   w_rlo_nxt  = 1'b1;
        OP_CLR:   w_rlo_nxt  = 1'b0;
        OP_NOT:   w_rlo_nxt  = !r_rlo;
        OP_JMPC:  w_cond_nxt = r_rlo;
        OP_JMPCN: w_cond_nxt = !r_rlo;
        default:  ;
      endcase
    end
  end

  rlo_lifo #(.DEPTH(STACK_DEPTH)) u_lifo (
    .CLK       (CLK),
    .CPU_Reset (CPU_Reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (w_push_entry),
    .o_top     (w_top),
    .o_depth   (RLO_Depth),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      r_rlo  <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_cond <= 1'b0;
    end else begin
      r_rlo  <= w_rlo_nxt;
      r_ovf  <= r_ovf | w_ovf_set;
      r_unf  <= r_unf | w_unf_set;
      r_cond <= w_cond_nxt;
    end
  end

  assign RLO_Value     = r_rlo;
  assign RLO_Overflow  = r_ovf;
  assign RLO_Underflow = r_unf;
  assign RLO_CondTaken = r_cond;

endmodule

// File: tb/tb_rlo_stack_unit.sv
// Directed bench for rlo_stack_unit: logic ops, nesting, saturation, sticky
// flags, jump pulses and asynchronous reset, with hand-computed expectations.
module tb_rlo_stack_unit;
  import rlo_stack_unit_pkg::*;

  localparam int SD = 8;

  logic                 CLK = 1'b0;
  logic                 CPU_Reset;
  logic                 RLO_EN;
  logic [3:0]           RLO_OPCode;
  logic                 RLO_SrcSel;
  logic                 RLO_CmpResult;
  logic                 RLO_BitIn;
  logic                 RLO_Value;
  logic [$clog2(SD):0]  RLO_Depth;
  logic                 RLO_Overflow;
  logic                 RLO_Underflow;
  logic                 RLO_CondTaken;

  int n_checks = 0;
  int n_errors = 0;

  rlo_stack_unit #(.STACK_DEPTH(SD)) dut (
    .CLK           (CLK),
    .CPU_Reset     (CPU_Reset),
    .RLO_EN        (RLO_EN),
    .RLO_OPCode    (RLO_OPCode),
    .RLO_SrcSel    (RLO_SrcSel),
    .RLO_CmpResult (RLO_CmpResult),
    .RLO_BitIn     (RLO_BitIn),
    .RLO_Value     (RLO_Value),
    .RLO_Depth     (RLO_Depth),
    .RLO_Overflow  (RLO_Overflow),
    .RLO_Underflow (RLO_Underflow),
    .RLO_CondTaken (RLO_CondTaken)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One instruction; the unselected operand carries the opposite value.
  task automatic step(input opcode_t op, input logic sel, input logic s);
    @(negedge CLK);
    RLO_EN        = 1'b1;
    RLO_OPCode    = op;
    RLO_SrcSel    = sel;
    RLO_BitIn     = sel ? s : ~s;
    RLO_CmpResult = sel ? ~s : s;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input opcode_t op);
    @(negedge CLK);
    RLO_EN        = 1'b0;
    RLO_OPCode    = op;
    RLO_SrcSel    = 1'b1;
    RLO_BitIn     = 1'b1;
    RLO_CmpResult = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RLO_EN    = 1'b0;
    CPU_Reset = 1'b1;
    @(negedge CLK);
    CPU_Reset = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic v, input int d,
                             input logic ovf, input logic unf, input logic ct);
    check({tag, ".value"}, 8'(RLO_Value), 8'(v));
    check({tag, ".depth"}, 8'(RLO_Depth), 8'(d));
    check({tag, ".ovf"},   8'(RLO_Overflow), 8'(ovf));
    check({tag, ".unf"},   8'(RLO_Underflow), 8'(unf));
    check({tag, ".cond"},  8'(RLO_CondTaken), 8'(ct));
  endtask

  initial begin
    CPU_Reset = 1'b1; RLO_EN = 1'b0; RLO_OPCode = 4'h0;
    RLO_SrcSel = 1'b0; RLO_CmpResult = 1'b0; RLO_BitIn = 1'b0;
    #2;
    check_state("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    CPU_Reset = 1'b0;

    // LD from comparator, AND with bit operand
    step(OP_LD, 1'b0, 1'b1);   check("ld_cmp", 8'(RLO_Value), 8'd1);
    step(OP_AND, 1'b1, 1'b0);  check("and_bit", 8'(RLO_Value), 8'd0);

    // Nested OR: values 1,0,1,1 with depth 0,1,1,0
    step(OP_LD, 1'b1, 1'b1);      check_state("nest_ld", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    step(OP_PUSH_OR, 1'b1, 1'b0); check_state("nest_push", 1'b0, 1, 1'b0, 1'b0, 1'b0);
    step(OP_OR, 1'b1, 1'b1);      check_state("nest_or", 1'b1, 1, 1'b0, 1'b0, 1'b0);
    step(OP_POP, 1'b0, 1'b0);     check_state("nest_pop", 1'b1, 0, 1'b0, 1'b0, 1'b0);

    // Nested AND: 1 AND (LDN 1 = 0) -> 0
    step(OP_LD, 1'b0, 1'b1);
    step(OP_PUSH_AND, 1'b1, 1'b1); check("pand_rlo", 8'(RLO_Value), 8'd1);
    step(OP_LDN, 1'b1, 1'b1);      check("ldn", 8'(RLO_Value), 8'd0);
    step(OP_POP, 1'b0, 1'b1);      check("pand_pop", 8'(RLO_Value), 8'd0);
    check("pand_depth", 8'(RLO_Depth), 8'd0);

    // Remaining single-operand ops
    step(OP_XOR, 1'b1, 1'b1);  check("xor1", 8'(RLO_Value), 8'd1);
    step(OP_XOR, 1'b0, 1'b1);  check("xor2", 8'(RLO_Value), 8'd0);
    step(OP_LD, 1'b1, 1'b1);
    step(OP_ANDN, 1'b1, 1'b0); check("andn", 8'(RLO_Value), 8'd1);
    step(OP_LDN, 1'b0, 1'b1);  check("ldn_cmp", 8'(RLO_Value), 8'd0);
    step(OP_ORN, 1'b1, 1'b1);  check("orn", 8'(RLO_Value), 8'd0);
    step(OP_NOT, 1'b1, 1'b0);  check("not", 8'(RLO_Value), 8'd1);
    step(OP_NOP, 1'b1, 1'b0);  check("nop", 8'(RLO_Value), 8'd1);
    idle(OP_CLR);              check("en_low", 8'(RLO_Value), 8'd1);

    // Underflow: POP on empty keeps RLO, flag sticks through later LD
    do_reset();
    step(OP_CLR, 1'b1, 1'b1);
    step(OP_POP, 1'b1, 1'b1);  check_state("unf_pop", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(OP_LD, 1'b1, 1'b1);   check_state("unf_ld", 1'b1, 0, 1'b0, 1'b1, 1'b0);

    // Overflow: eight pushes of 0, ninth push of 1 must be rejected
    do_reset();
    step(OP_LD, 1'b1, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      step(OP_PUSH_AND, 1'b1, (i == 9));
      check($sformatf("ovf_depth%0d", i), 8'(RLO_Depth), 8'((i > SD) ? SD : i));
      check($sformatf("ovf_flag%0d", i), 8'(RLO_Overflow), 8'(i > SD));
    end
    check("ovf_rlo", 8'(RLO_Value), 8'd0);
    for (int i = 0; i < SD; i++) step(OP_POP, 1'b1, 1'b0);
    check_state("ovf_drain", 1'b0, 0, 1'b1, 1'b0, 1'b0);

    // Conditional jump pulses
    do_reset();
    step(OP_SET, 1'b1, 1'b0);   check("ct_set", 8'(RLO_CondTaken), 8'd0);
    step(OP_JMPC, 1'b1, 1'b0);  check("ct_jmpc", 8'(RLO_CondTaken), 8'd1);
    step(OP_JMPCN, 1'b1, 1'b0); check("ct_jmpcn", 8'(RLO_CondTaken), 8'd0);
    check("ct_rlo", 8'(RLO_Value), 8'd1);
    step(OP_CLR, 1'b1, 1'b0);   check("ct_clr", 8'(RLO_CondTaken), 8'd0);
    step(OP_JMPCN, 1'b1, 1'b0); check("ct_jmpcn0", 8'(RLO_CondTaken), 8'd1);
    step(OP_JMPC, 1'b1, 1'b0);  check("ct_jmpc0", 8'(RLO_CondTaken), 8'd0);
    step(OP_JMPCN, 1'b1, 1'b0); check("ct_jmpcn1", 8'(RLO_CondTaken), 8'd1);
    idle(OP_JMPCN);             check("ct_idle", 8'(RLO_CondTaken), 8'd0);

    // Reset mid-nesting, between clock edges
    do_reset();
    step(OP_LD, 1'b1, 1'b1);
    step(OP_PUSH_OR, 1'b1, 1'b1);
    step(OP_PUSH_OR, 1'b1, 1'b1);
    step(OP_PUSH_OR, 1'b1, 1'b1);
    check("mid_depth3", 8'(RLO_Depth), 8'd3);
    @(negedge CLK);
    RLO_EN = 1'b0;
    #2 CPU_Reset = 1'b1;
    #1 check_state("mid_rst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    CPU_Reset = 1'b0;
    step(OP_POP, 1'b1, 1'b1);   check_state("post_rst_pop", 1'b0, 0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rlo_stack_unit.md
RLO_STACK_UNIT -- requirements
Module: rlo_stack_unit

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, number of nesting levels (power of two, 2..16).
REQ-002 SHALL have clock CLK, input, 1, rising-edge clock.
REQ-003 SHALL have reset CPU_Reset, input, 1, asynchronous, active-high.
REQ-004 SHALL have RLO_EN, input, 1, instruction valid this cycle; all other inputs are ignored when low.
REQ-005 SHALL have RLO_OPCode, input, 4, logic operation code (REQ-012).
REQ-006 SHALL have RLO_SrcSel, input, 1, operand select: 0 = comparator result, 1 = bit operand.
REQ-007 SHALL have RLO_CmpResult, input, 1, registered comparator flag from the comparator register stage.
REQ-008 SHALL have RLO_BitIn, input, 1, bit operand from the PLC bit memory.
REQ-009 SHALL have RLO_Value, output, 1, current result of logic operation (RLO).
REQ-010 SHALL have RLO_Depth, output, $clog2(STACK_DEPTH)+1, number of occupied stack entries.
REQ-011 SHALL have RLO_Overflow, RLO_Underflow, RLO_CondTaken, outputs, 1 each: sticky push-full error, sticky pop-empty error, and conditional-jump decision pulse.

Function
REQ-012 Opcodes, with S = the selected operand: 0 NOP; 1 LD (RLO=S); 2 LDN (RLO=!S); 3 AND; 4 ANDN; 5 OR; 6 ORN; 7 XOR; 8 PUSH_AND; 9 PUSH_OR; A POP; B SET (RLO=1); C CLR (RLO=0); D NOT (RLO=!RLO); E JMPC; F JMPCN.
REQ-013 All state SHALL update on the CLK rising edge when RLO_EN=1; the result is visible on RLO_Value one cycle after the instruction (latency 1).
REQ-014 PUSH_AND/PUSH_OR SHALL store the pair {pending op, RLO} at index Depth, increment Depth, and set RLO=S.
REQ-015 POP SHALL decrement Depth and set RLO = stored_RLO AND/OR current RLO, per the stored op.
REQ-016 PUSH with Depth==STACK_DEPTH SHALL leave the stack, Depth and RLO unchanged and set RLO_Overflow.
REQ-017 POP with Depth==0 SHALL leave RLO and Depth unchanged and set RLO_Underflow.
REQ-018 RLO_Overflow and RLO_Underflow SHALL stay set until reset.
REQ-019 JMPC SHALL drive RLO_CondTaken=RLO and JMPCN SHALL drive RLO_CondTaken=!RLO, each for exactly one cycle after the instruction; RLO is unchanged.
REQ-020 RLO_CondTaken SHALL be 0 in every other cycle, including back-to-back non-jump instructions.
REQ-021 Back-to-back instructions SHALL be accepted every cycle, with no stall.
REQ-022 The operand SHALL be sampled in the same cycle as RLO_EN; the comparator flag is consumed as-is, with no extra synchronisation.

Reset
REQ-023 CPU_Reset SHALL force RLO_Value=0, RLO_Depth=0, RLO_Overflow=0, RLO_Underflow=0 and RLO_CondTaken=0 immediately, regardless of CLK.
REQ-024 Stack storage contents need not be cleared; entries above Depth are don't-care.
REQ-025 Reset asserted mid-sequence, for example with Depth=3, SHALL discard all nesting, and the first instruction after release SHALL execute against an empty stack.

Structure
REQ-026 A shared package SHALL hold the opcode constants, the STACK_DEPTH default, and the stack entry type {op:1, value:1}.
REQ-027 The LIFO storage SHALL be one sub-module, rlo_lifo (push, pop, depth, full, empty); the opcode decode and RLO register SHALL stay in the top module.
REQ-028 The block SHALL need no clock enables other than RLO_EN and SHALL contain no latches.

Verification
REQ-029 Reset, then LD with CmpResult=1, then AND with BitIn=0 (SrcSel=1) -> RLO_Value=1 after cycle 1, then 0 after cycle 2.
REQ-030 LD 1, PUSH_OR with S=0, OR with S=1, POP -> Depth sequence 0,1,1,0; final RLO=1; intermediate RLO values 1,0,1,1.
REQ-031 Nine PUSH_AND operations with STACK_DEPTH=8 -> Depth saturates at 8, RLO_Overflow=1 after the 9th push, and RLO is unchanged by the 9th push.
REQ-032 POP at Depth=0 -> RLO_Underflow=1 and RLO unchanged; a subsequent LD 1 still gives RLO=1 with the flag still set.
REQ-033 SET then JMPC then JMPCN -> RLO_CondTaken sequence 0,1,0 on the cycles after each instruction; a CLR followed by JMPCN -> pulse of 1.
REQ-034 PUSH three times, then assert CPU_Reset between clock edges -> all outputs 0 before the next edge; a POP after release -> RLO_Underflow=1.
